alu_exec_stage: RTL and testbench

Execute stage that sits directly upstream of the ALU result consumers and wraps the ALU datapath: add, sub, and, xor.
- Registers operands, the function code and the condition-select code behind a valid/ready handshake.
- Produces a registered result plus the Y86 condition flag cnd.
- Owns the condition-code register (ZF, SF, OF).
- Feeds the memory/writeback stage downstream.

---
 rtl/alu_exec_stage.sv | 78 +++++++
 tb/tb_alu_exec_stage.sv | 120 ++++++++++++
 2 files changed

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered add/sub/and/xor execute stage with Y86 condition codes and a valid/ready output slot
module alu_exec_stage #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   alu_fn,
  input  logic [2:0]   cond_fn,
  input  logic         set_cc,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         cnd,
  output logic         zf,
  output logic         sf,
  output logic         of
);
  logic         out_valid_q, out_valid_d;
  logic [W-1:0] result_q, result_d;
  logic         cnd_q, cnd_d;
  logic         zf_q, zf_d, sf_q, sf_d, of_q, of_d;
  logic [W-1:0] r;
  logic         r_of, c, lt, acc;
  always_comb begin
    r = alu_fn == 2'd0 ? b + a :
        alu_fn == 2'd1 ? b - a :
        alu_fn == 2'd2 ? a & b : a ^ b;
    r_of = alu_fn == 2'd0 ? (a[W-1] == b[W-1]) && (r[W-1] != b[W-1]) :
           alu_fn == 2'd1 ? (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]) : 1'b0;
    // Condition sees CC as it stands before this op's own flag update
    lt = sf_q ^ of_q;
    c = cond_fn == 3'd0 ? 1'b1 :
        cond_fn == 3'd1 ? lt | zf_q :
        cond_fn == 3'd2 ? lt :
        cond_fn == 3'd3 ? zf_q :
        cond_fn == 3'd4 ? !zf_q :
        cond_fn == 3'd5 ? !lt :
        cond_fn == 3'd6 ? !lt && !zf_q : 1'b0;
  end
  assign in_ready = rst_n && !flush && (!out_valid_q || out_ready);
  assign acc = in_valid && in_ready;
  always_comb begin
    out_valid_d = flush ? 1'b0 : acc ? 1'b1 : out_ready ? 1'b0 : out_valid_q;
    result_d    = acc ? r : result_q;
    cnd_d       = acc ? c : cnd_q;
    zf_d        = acc && set_cc ? r == '0 : zf_q;
    sf_d        = acc && set_cc ? r[W-1] : sf_q;
    of_d        = acc && set_cc ? r_of : of_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cnd_q       <= 1'b0;
      zf_q        <= 1'b1;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cnd_q       <= cnd_d;
      zf_q        <= zf_d;
      sf_q        <= sf_d;
      of_q        <= of_d;
    end
  end
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cnd       = cnd_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: directed vector table plus handshake corner sequences
module tb_alu_exec_stage;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, set_cc, out_valid, out_ready, cnd, zf, sf, of;
  logic [1:0]  alu_fn;
  logic [2:0]  cond_fn;
  logic [31:0] a, b, result;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [1:0]  fn;
    logic [2:0]  cf;
    logic        sc;
    logic [31:0] a, b, r;
    logic        c, z, s, o;
  } vec_t;
  vec_t vt[13];
  alu_exec_stage #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_fn(alu_fn), .cond_fn(cond_fn), .set_cc(set_cc), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .cnd(cnd),
    .zf(zf), .sf(sf), .of(of)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string name, input logic v, input logic [31:0] r, input logic c,
                         input logic z, input logic s, input logic o);
    chk({name, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({name, ".result"}, result, r);
    chk({name, ".cnd"}, {31'd0, cnd}, {31'd0, c});
    chk({name, ".zf"}, {31'd0, zf}, {31'd0, z});
    chk({name, ".sf"}, {31'd0, sf}, {31'd0, s});
    chk({name, ".of"}, {31'd0, of}, {31'd0, o});
  endtask
  task automatic drive(input logic [1:0] fn, input logic [2:0] cf, input logic sc,
                       input logic [31:0] va, input logic [31:0] vb);
    alu_fn = fn; cond_fn = cf; set_cc = sc; a = va; b = vb;
  endtask
  initial begin
    vt[0]  = '{2'd0, 3'd0, 1'b1, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[1]  = '{2'd1, 3'd2, 1'b1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{2'd3, 3'd3, 1'b0, 32'h0000000B, 32'h00000004, 32'h0000000F, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{2'd3, 3'd4, 1'b0, 32'h0000000B, 32'h0000000C, 32'h00000007, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4]  = '{2'd1, 3'd1, 1'b1, 32'h0000000D, 32'hFFFFFFFE, 32'hFFFFFFF1, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{2'd2, 3'd2, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[6]  = '{2'd0, 3'd5, 1'b1, 32'h80000000, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{2'd1, 3'd6, 1'b1, 32'h00000001, 32'h80000000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{2'd2, 3'd7, 1'b0, 32'hFFFFFFFF, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{2'd3, 3'd1, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[10] = '{2'd0, 3'd6, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[11] = '{2'd1, 3'd5, 1'b1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[12] = '{2'd0, 3'd6, 1'b0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b1, 1'b0, 1'b1, 1'b1};
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'd0, 3'd0, 1'b0, 32'd0, 32'd0);
    #12;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
    chk_out("reset", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_out("idle", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle.in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].fn, vt[i].cf, vt[i].sc, vt[i].a, vt[i].b);
      chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk_out($sformatf("vec%0d", i), 1'b1, vt[i].r, vt[i].c, vt[i].z, vt[i].s, vt[i].o);
    end
    // Stall with a flag-setting op waiting upstream; nothing may move
    out_ready = 1'b0;
    drive(2'd0, 3'd0, 1'b1, 32'd1, 32'd1);
    #1;
    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_out($sformatf("stall%0d", i), 1'b1, 32'h5, 1'b1, 1'b0, 1'b1, 1'b1);
      chk($sformatf("stall%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk_out("release", 1'b1, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk_out("drain", 1'b0, 32'h2, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    drive(2'd3, 3'd7, 1'b0, 32'd1, 32'd6);
    @(posedge clk); #1;
    chk_out("refill", 1'b1, 32'h7, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    drive(2'd0, 3'd0, 1'b1, 32'd0, 32'd0);
    #1;
    chk("flush.in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("flush.out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush.cc", {29'd0, zf, sf, of}, 32'd0);
    flush = 1'b0;
    drive(2'd0, 3'd0, 1'b1, 32'd1, 32'd2);
    @(posedge clk); #1;
    chk_out("pre_rst", 1'b1, 32'h3, 1'b1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("mid_rst.in_ready", {31'd0, in_ready}, 32'd0);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_out("post_rst", 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
